// File: rtl/inv_sub_shift_key.sv
// Iterative AES decrypt pre-mix stage: AddRoundKey(InvSubBytes(InvShiftRows(state))) using LANES S-box lanes.
// Optional sideband: define INV_SUB_SHIFT_KEY_LAST_EN to add in_last/out_last.
module inv_sub_shift_key #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
    input  logic         in_last,
    output logic         out_last,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_fsm;
    state_t        w_fsm_next;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_state;
    logic [127:0]  r_key;
    logic [127:0]  r_out_data;
    logic          r_out_valid;
    logic          w_accept;
    logic          w_last_sub;
    logic          w_release;
    logic [127:0]  w_shifted;
    logic [127:0]  w_sub_state;
    logic [7:0]    w_byte     [16];
    logic [7:0]    w_lane_out [LANES];
    logic [3:0]    w_lane_idx [LANES];
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
    logic          r_last;
    logic          r_out_last;
`endif

    // Byte k lives at row k%4, column k/4; row r is rotated right by r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
        assign w_shifted[127-8*gi -: 8]   = in_state[127-8*SRC -: 8];
        assign w_byte[gi]                 = r_state[127-8*gi -: 8];
        assign w_sub_state[127-8*gi -: 8] = (r_cnt == CW'(gi / LANES)) ?
                                            w_lane_out[gi % LANES] : w_byte[gi];
    end

    // Only LANES S-boxes exist; each one walks its slot across the state.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_idx[gi] = 4'(int'(r_cnt) * LANES + gi);
        assign w_lane_out[gi] = inv_sbox(w_byte[w_lane_idx[gi]]);
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_last_sub = 1'b0;
        w_release  = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (in_valid) begin
                    w_accept   = 1'b1;
                    w_fsm_next = SUB;
                end
            end
            SUB: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_last_sub = 1'b1;
                    w_fsm_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_release  = 1'b1;
                    w_fsm_next = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
            r_last      <= 1'b0;
            r_out_last  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_state <= w_shifted;
                r_key   <= in_key;
                r_cnt   <= '0;
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
                r_last  <= in_last;
`endif
            end else if (r_fsm == SUB) begin
                r_state <= w_sub_state;
                r_cnt   <= r_cnt + 1'b1;
            end

            // The result register only changes on the final lookup cycle.
            if (w_last_sub) begin
                r_out_data  <= w_sub_state ^ r_key;
                r_out_valid <= 1'b1;
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
                r_out_last  <= r_last;
`endif
            end else if (w_release) begin
                r_out_valid <= 1'b0;
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
                r_out_last  <= 1'b0;
`endif
            end
        end
    end

    assign in_ready  = rst_n && (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`ifdef INV_SUB_SHIFT_KEY_LAST_EN
    assign out_last  = r_out_last;
`endif

endmodule
